alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width.
REQ-002 Parameter REG_AW, default 5: register-address width.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port in_valid  input  1: the decode stage presents an instruction.
REQ-006 Port in_ready  output  1: the stage accepts the instruction this cycle.
REQ-007 Ports rs_addr, rt_addr, rd_addr  input  REG_AW: source and destination register numbers.
REQ-008 Ports rs_data, rt_data  input  DATA_W: register-file read data.
REQ-009 Port imm  input  16: instruction immediate.
REQ-010 Port zero_ext  input  1: 1 = zero-extend imm, 0 = sign-extend imm.
REQ-011 Port alu_src  input  1: 1 = B operand is the extended immediate, 0 = B operand is rt.
REQ-012 Port alu_op  input  2: main-decoder ALU class.
REQ-013 Port funct  input  6: R-type function field.
REQ-014 Ports exmem_wr, memwb_wr  input  1: forwarding-source write enables.
REQ-015 Ports exmem_rd, memwb_rd  input  REG_AW: forwarding-source destination registers.
REQ-016 Ports exmem_data, memwb_data  input  DATA_W: forwarding-source result data.
REQ-017 Port flush  input  1: kill the held and incoming instruction.
REQ-018 Port out_valid  output  1: the registered ALU operands are valid.
REQ-019 Port out_ready  input  1: the ALU/EX consumer accepts the operands.
REQ-020 Ports alu_a, alu_b  output  DATA_W: registered ALU operands A and B.
REQ-021 Port alu_opcode  output  4: registered 4-bit ALU operation code.
REQ-022 Port out_rd  output  REG_AW: registered destination register.
REQ-023 Port illegal  output  1: registered flag marking an unsupported funct code.

Function
REQ-024 The stage SHALL be a single pipeline register with combinational in_ready = !out_valid || out_ready.
REQ-025 A transfer SHALL occur when in_valid && in_ready; on that edge all outputs load and out_valid becomes 1.
REQ-026 When out_valid && out_ready and no input transfer occurs, out_valid SHALL clear on the next edge.
REQ-027 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-028 Latency from input transfer to out_valid SHALL be exactly one cycle, with full throughput of one instruction per cycle.
REQ-029 The forwarded rs operand SHALL be exmem_data if exmem_wr && exmem_rd==rs_addr && rs_addr!=0; otherwise memwb_data under the same rule for MEM/WB; otherwise rs_data.
REQ-030 The forwarded rt operand SHALL use the same rule as REQ-029; EX/MEM SHALL take priority over MEM/WB.
REQ-031 alu_a SHALL be the forwarded rs operand.
REQ-032 alu_b SHALL be the extended imm when alu_src=1, otherwise the forwarded rt operand.
REQ-033 Immediate extension SHALL replicate imm[15] into the upper bits when zero_ext=0, and SHALL fill the upper bits with 0 when zero_ext=1.
REQ-034 alu_opcode by alu_op: 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0001 (or).
REQ-035 alu_op=10 SHALL decode funct as 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
REQ-036 Any other funct under alu_op=10 SHALL produce alu_opcode 1111 and illegal=1; illegal SHALL be 0 in every other case.
REQ-037 When flush is asserted, out_valid SHALL be 0 after the edge regardless of in_valid or out_ready, and no input transfer SHALL be counted.
REQ-038 Data outputs SHALL NOT change when flush is asserted.
REQ-039 Simultaneous input transfer and output consume SHALL load the new instruction and keep out_valid at 1.

Reset
REQ-040 While rst_n=0, out_valid, alu_a, alu_b, out_rd and illegal SHALL be 0, and alu_opcode SHALL be 0000, asynchronously.
REQ-041 Reset mid-transfer SHALL discard the in-flight instruction.
REQ-042 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-043 The alu_op encodings, funct constants and 4-bit ALU opcode constants SHALL live in a shared package (mips_pkg), which the ALU also uses.
REQ-044 The ALU-control decode SHALL be one combinational sub-module, alu_control (inputs alu_op and funct; outputs opcode and illegal), instantiated once.
REQ-045 The forwarding muxes SHALL be inline in this module.

Verification
REQ-046 Inputs rs_data=5, rt_data=3, alu_op=10, funct=100010, out_ready=1 -> the next cycle gives out_valid=1, alu_a=5, alu_b=3, alu_opcode=0110.
REQ-047 Inputs imm=16'hFFFF, alu_src=1: zero_ext=0 -> alu_b=32'hFFFFFFFF; zero_ext=1 -> alu_b=32'h0000FFFF.
REQ-048 Inputs rs_addr=7, exmem_wr=1, exmem_rd=7, exmem_data=0xAA, memwb_wr=1, memwb_rd=7, memwb_data=0xBB -> alu_a=0xAA; with rs_addr=0 and both sources targeting register 0 -> alu_a=rs_data.
REQ-049 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout; out_ready=1 -> the next instruction loads on that edge.
REQ-050 Input alu_op=10, funct=000000 -> alu_opcode=1111, illegal=1.
REQ-051 flush with a held instruction -> out_valid=0 next cycle; rst_n pulsed low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: main-decoder ALU classes, R-type funct
// codes and the 4-bit ALU operation codes used by issue and execute.
package mips_pkg;

   // Main-decoder ALU class carried on alu_op
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_OR    = 2'b11
   } alu_op_e;

   // R-type function field values understood by the ALU
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;

   // 4-bit ALU operation codes
   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_SLT     = 4'b0111;
   localparam logic [3:0] ALU_NOR     = 4'b1100;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

endpackage : mips_pkg

// File: rtl/alu_control.sv
// ALU-control decode: maps the main-decoder class and the R-type funct
// field onto a 4-bit ALU opcode, flagging funct codes the ALU cannot run.
module alu_control
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] opcode,
   output logic       illegal
);

   // Class decode first, funct decode only for R-type instructions
   always_comb begin
      opcode  = ALU_ADD;
      illegal = 1'b0;
      case (alu_op_e'(alu_op))
         ALUOP_ADD: opcode = ALU_ADD;
         ALUOP_SUB: opcode = ALU_SUB;
         ALUOP_OR:  opcode = ALU_OR;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: opcode = ALU_ADD;
               FUNCT_SUB: opcode = ALU_SUB;
               FUNCT_AND: opcode = ALU_AND;
               FUNCT_OR:  opcode = ALU_OR;
               FUNCT_SLT: opcode = ALU_SLT;
               FUNCT_NOR: opcode = ALU_NOR;
               default: begin
                  opcode  = ALU_ILLEGAL;
                  illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule : alu_control

// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves forwarded operands, extends the immediate,
// decodes the ALU opcode and registers the result in a single
// valid/ready pipeline register feeding the EX stage.
module alu_issue_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
)(
   input  logic              clk,
   input  logic              rst_n,
   // decode side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [15:0]       imm,
   input  logic              zero_ext,
   input  logic              alu_src,
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   // forwarding sources
   input  logic              exmem_wr,
   input  logic              memwb_wr,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic [DATA_W-1:0] memwb_data,
   // pipeline control
   input  logic              flush,
   // EX side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_opcode,
   output logic [REG_AW-1:0] out_rd,
   output logic              illegal
);

   // Handshake: a beat moves whenever valid and ready are both high on a
   // rising edge; valid never waits on ready, and a producer holding
   // valid keeps its payload stable until the beat moves. in_ready is
   // high when the register is empty or is being drained this cycle, so
   // a new instruction can follow every cycle. flush overrides both
   // sides: nothing is accepted, the held beat is dropped, data holds.

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] opnd_b;
   logic [3:0]        dec_opcode;
   logic              dec_illegal;
   logic              exmem_hit_rs;
   logic              memwb_hit_rs;
   logic              exmem_hit_rt;
   logic              memwb_hit_rt;
   logic              load;

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready && !flush;

   // Register 0 is hard-wired zero, so a write aimed at it never forwards
   assign exmem_hit_rs = exmem_wr && (exmem_rd == rs_addr) && (rs_addr != '0);
   assign memwb_hit_rs = memwb_wr && (memwb_rd == rs_addr) && (rs_addr != '0);
   assign exmem_hit_rt = exmem_wr && (exmem_rd == rt_addr) && (rt_addr != '0);
   assign memwb_hit_rt = memwb_wr && (memwb_rd == rt_addr) && (rt_addr != '0);

   // Forwarding muxes: the younger EX/MEM result wins over MEM/WB
   always_comb begin
      fwd_rs = rs_data;
      fwd_rt = rt_data;
      if (exmem_hit_rs) begin
         fwd_rs = exmem_data;
      end else if (memwb_hit_rs) begin
         fwd_rs = memwb_data;
      end
      if (exmem_hit_rt) begin
         fwd_rt = exmem_data;
      end else if (memwb_hit_rt) begin
         fwd_rt = memwb_data;
      end
   end

   // Immediate extension and B-operand select
   always_comb begin
      imm_ext = {{(DATA_W-16){imm[15] & ~zero_ext}}, imm};
      opnd_b  = alu_src ? imm_ext : fwd_rt;
   end

   alu_control u_alu_control (
      .alu_op  (alu_op),
      .funct   (funct),
      .opcode  (dec_opcode),
      .illegal (dec_illegal)
   );

   // Output pipeline register: flush drops the beat, load captures, drain clears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= 4'b0000;
         out_rd     <= '0;
         illegal    <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
      end else if (load) begin
         out_valid  <= 1'b1;
         alu_a      <= fwd_rs;
         alu_b      <= opnd_b;
         alu_opcode <= dec_opcode;
         out_rd     <= rd_addr;
         illegal    <= dec_illegal;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases followed by random traffic,
// all checked against a behavioural model of the stage.
module tb_alu_issue_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int W = 1 + 4 + REG_AW + 2 * DATA_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              in_valid, in_ready;
   logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
   logic [DATA_W-1:0] rs_data, rt_data;
   logic [15:0]       imm;
   logic              zero_ext, alu_src;
   logic [1:0]        alu_op;
   logic [5:0]        funct;
   logic              exmem_wr, memwb_wr;
   logic [REG_AW-1:0] exmem_rd, memwb_rd;
   logic [DATA_W-1:0] exmem_data, memwb_data;
   logic              flush;
   logic              out_valid, out_ready;
   logic [DATA_W-1:0] alu_a, alu_b;
   logic [3:0]        alu_opcode;
   logic [REG_AW-1:0] out_rd;
   logic              illegal;

   alu_issue_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .rs_data(rs_data), .rt_data(rt_data),
      .imm(imm), .zero_ext(zero_ext), .alu_src(alu_src),
      .alu_op(alu_op), .funct(funct),
      .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_data(exmem_data), .memwb_data(memwb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .out_rd(out_rd), .illegal(illegal)
   );

   // ---------------- scoreboard state ----------------
   int             n_tests = 0;
   int             n_fail  = 0;
   logic [W-1:0]   exp_q[$];
   logic           m_valid;
   logic [W-1:0]   m_data;
   logic [W-1:0]   held;

   logic [5:0] legal_funct [6] = '{6'b100000, 6'b100010, 6'b100100,
                                   6'b100101, 6'b101010, 6'b100111};

   function automatic logic [W-1:0] obs_payload();
      return {illegal, alu_opcode, out_rd, alu_b, alu_a};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // ALU control table: returns {illegal, opcode}
   function automatic logic [4:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'd0) return {1'b0, 4'd2};
      if (op == 2'd1) return {1'b0, 4'd6};
      if (op == 2'd3) return {1'b0, 4'd1};
      case (f)
         6'd32:   return {1'b0, 4'd2};
         6'd34:   return {1'b0, 4'd6};
         6'd36:   return {1'b0, 4'd0};
         6'd37:   return {1'b0, 4'd1};
         6'd42:   return {1'b0, 4'd7};
         6'd39:   return {1'b0, 4'd12};
         default: return {1'b1, 4'd15};
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] ref_fwd(input logic [REG_AW-1:0] a,
                                                 input logic [DATA_W-1:0] rf);
      if (a == 0) return rf;
      if (exmem_wr && exmem_rd == a) return exmem_data;
      if (memwb_wr && memwb_rd == a) return memwb_data;
      return rf;
   endfunction

   function automatic logic [W-1:0] ref_payload();
      logic [DATA_W-1:0] b;
      logic signed [DATA_W-1:0] s;
      if (alu_src) begin
         s = $signed(imm);
         b = zero_ext ? DATA_W'(imm) : s;
      end else begin
         b = ref_fwd(rt_addr, rt_data);
      end
      return {ref_ctrl(alu_op, funct), rd_addr, b, ref_fwd(rs_addr, rs_data)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd3;
      rs_data = '0; rt_data = '0; imm = '0; zero_ext = 1'b0; alu_src = 1'b0;
      alu_op = 2'b00; funct = 6'b000000;
      exmem_wr = 1'b0; memwb_wr = 1'b0; exmem_rd = '0; memwb_rd = '0;
      exmem_data = '0; memwb_data = '0;
   endtask

   task automatic rand_inputs();
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      rs_addr    = REG_AW'($urandom_range(0, 3));
      rt_addr    = REG_AW'($urandom_range(0, 3));
      rd_addr    = REG_AW'($urandom_range(0, 31));
      rs_data    = $urandom; rt_data = $urandom;
      imm        = 16'($urandom);
      zero_ext   = 1'($urandom_range(0, 1));
      alu_src    = 1'($urandom_range(0, 1));
      alu_op     = 2'($urandom_range(0, 3));
      funct      = ($urandom_range(0, 1) != 0) ? legal_funct[$urandom_range(0, 5)]
                                               : 6'($urandom);
      exmem_wr   = 1'($urandom_range(0, 1));
      memwb_wr   = 1'($urandom_range(0, 1));
      exmem_rd   = REG_AW'($urandom_range(0, 3));
      memwb_rd   = REG_AW'($urandom_range(0, 3));
      exmem_data = $urandom; memwb_data = $urandom;
   endtask

   // One clock: entered at negedge with inputs set, returns at next negedge
   task automatic cycle();
      logic         xfer;
      logic [W-1:0] nxt;
      logic [W-1:0] front;
      #1;
      chk("in_ready", W'(in_ready), W'(!m_valid || out_ready));
      if (m_valid && out_ready && !flush) begin
         chk("consume_q_nonempty", W'(exp_q.size() != 0), W'(1));
         if (exp_q.size() != 0) begin
            front = exp_q.pop_front();
            chk("consume_payload", obs_payload(), front);
         end
      end
      xfer = in_valid && (!m_valid || out_ready) && !flush;
      nxt  = ref_payload();
      @(posedge clk);
      if (flush) begin
         m_valid = 1'b0;
         exp_q.delete();
      end else if (xfer) begin
         m_valid = 1'b1;
         m_data  = nxt;
         exp_q.push_back(nxt);
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk("out_valid", W'(out_valid), W'(m_valid));
      chk("out_payload", obs_payload(), m_data);
      @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      set_idle();
      rst_n   = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      #2;
      chk("reset_valid", W'(out_valid), W'(0));
      chk("reset_payload", obs_payload(), '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Subtract through the R-type path, first edge after reset
      rs_data = 32'd5; rt_data = 32'd3; alu_op = 2'b10; funct = 6'b100010;
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      chk("sub_valid", W'(out_valid), W'(1));
      chk("sub_a", W'(alu_a), W'(5));
      chk("sub_b", W'(alu_b), W'(3));
      chk("sub_opcode", W'(alu_opcode), W'(4'b0110));

      // Immediate sign / zero extension
      alu_src = 1'b1; imm = 16'hFFFF; zero_ext = 1'b0;
      cycle();
      chk("imm_sext", W'(alu_b), W'(32'hFFFF_FFFF));
      zero_ext = 1'b1;
      cycle();
      chk("imm_zext", W'(alu_b), W'(32'h0000_FFFF));

      // Forwarding priority and register-0 exclusion
      alu_src = 1'b0; rs_addr = 5'd7; rs_data = 32'h1111;
      exmem_wr = 1'b1; exmem_rd = 5'd7; exmem_data = 32'hAA;
      memwb_wr = 1'b1; memwb_rd = 5'd7; memwb_data = 32'hBB;
      cycle();
      chk("fwd_exmem_prio", W'(alu_a), W'(32'hAA));
      rs_addr = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0; rs_data = 32'h1234;
      cycle();
      chk("fwd_reg0", W'(alu_a), W'(32'h1234));
      exmem_wr = 1'b0; memwb_wr = 1'b0;

      // Unsupported funct
      alu_op = 2'b10; funct = 6'b000000;
      cycle();
      chk("illegal_opcode", W'(alu_opcode), W'(4'b1111));
      chk("illegal_flag", W'(illegal), W'(1));

      // Back-pressure: three stalled cycles, then release
      held = obs_payload();
      out_ready = 1'b0; in_valid = 1'b1; alu_op = 2'b00; rs_addr = 5'd4;
      for (int i = 0; i < 3; i++) begin
         rs_data = 32'h50 + 32'(i);
         cycle();
         chk("stall_in_ready", W'(in_ready), W'(0));
         chk("stall_stable", obs_payload(), held);
      end
      out_ready = 1'b1; rs_data = 32'h66;
      cycle();
      chk("release_load", W'(alu_a), W'(32'h66));
      chk("release_opcode", W'(alu_opcode), W'(4'b0010));

      // Flush of a held instruction keeps data, drops valid
      out_ready = 1'b0; in_valid = 1'b0;
      cycle();
      held = obs_payload();
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rs_data = 32'h77;
      cycle();
      chk("flush_valid", W'(out_valid), W'(0));
      chk("flush_data_hold", obs_payload(), held);
      flush = 1'b0; in_valid = 1'b0;
      cycle();

      // Asynchronous reset mid-stream
      in_valid = 1'b1; out_ready = 1'b0; rs_data = 32'h99; rd_addr = 5'd9;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", W'(out_valid), W'(0));
      chk("async_rst_payload", obs_payload(), '0);
      m_valid = 1'b0; m_data = '0; exp_q.delete();
      @(posedge clk);
      #1;
      chk("rst_held_valid", W'(out_valid), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      set_idle();
      cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         cycle();
      end

      // Drain
      set_idle();
      cycle();
      cycle();
      chk("drain_q_empty", W'(exp_q.size()), W'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_alu_issue_stage
